frmbuf_wr_req: RTL and testbench

- Write-channel client of the two-channel DDR3 frame-buffer arbiter.
- Drains a first-word-fall-through line FIFO holding 256-bit video words.
- Asks the arbiter for a grant with a request/response handshake, then issues a burst of write commands and write data to the DDR3 app interface.
- Pulses burst-end to release the grant, and advances a linear frame address from frame start to frame end.

---
 rtl/frmbuf_wr_req.sv | 203 ++++++++++++++++++++
 tb/tb_frmbuf_wr_req.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frmbuf_wr_req.sv
// Frame-buffer write client: drains a FWFT line FIFO into DDR3 write bursts.
// Optional `FRMBUF_WR_PINGPONG_EN adds o_buf_sel and alternates frame bases.
module frmbuf_wr_req #(
  parameter int          P_BURST_LEN    = 32,
  parameter int          P_FRAME_WORDS  = 76800,
  parameter logic [26:0] P_BASE_ADDR    = 27'h0,
  parameter int          P_ADDR_STEP    = 8,
  parameter logic [26:0] P_FRAME_OFFSET = 27'h0100000
) (
  input  logic         i_ddr3_clk,
  input  logic         i_rst_n,
  input  logic         i_system_init,
  input  logic         i_frame_start,
  input  logic [9:0]   i_fifo_cnt,
  input  logic [255:0] i_fifo_data,
  output logic         o_fifo_rd,
  output logic         o_request,
  input  logic         i_response,
  output logic         o_bust_end,
  output logic [26:0]  o_req_addr,
  output logic         o_cmd_valid,
  output logic [2:0]   o_rdwr_cmd,
  output logic         o_wr_en,
  output logic [255:0] o_wr_data,
  input  logic         i_app_rdy,
  input  logic         i_app_wdf_rdy,
  output logic         o_frame_done,
`ifdef FRMBUF_WR_PINGPONG_EN
  output logic         o_buf_sel,
`endif
  output logic         o_busy
);

  localparam int BW = $clog2(P_BURST_LEN + 1);
  localparam int FW = $clog2(P_FRAME_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_BURST,
    S_END
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [BW-1:0] blen_q, blen_d;
  logic [BW-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [BW-1:0] dat_cnt_q, dat_cnt_d;
  logic [26:0]   req_addr_q, req_addr_d;
  logic          request_q, request_d;
  logic          frame_done_q, frame_done_d;
  logic          buf_sel_q;

  logic [31:0]   rem;
  logic [31:0]   blen_calc;
  logic [31:0]   frame_sum;
  logic          thresh;
  logic [26:0]   frame_base;
  logic          in_burst;
  logic          wr_en;
  logic          cmd_valid;
  logic          cmd_acc;

`ifdef FRMBUF_WR_PINGPONG_EN
  logic buf_sel_d;

  // Flip the buffer select together with the frame-done pulse.
  always_comb begin
    buf_sel_d = buf_sel_q ^ frame_done_d;
  end

  // Buffer select register.
  always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      buf_sel_q <= 1'b0;
    end else begin
      buf_sel_q <= buf_sel_d;
    end
  end

  assign o_buf_sel = buf_sel_q;
`else
  assign buf_sel_q = 1'b0;
`endif

  // Burst sizing, threshold and handshake gating.
  always_comb begin
    rem       = 32'(P_FRAME_WORDS) - 32'(frame_cnt_q);
    blen_calc = (rem < 32'(P_BURST_LEN)) ? rem : 32'(P_BURST_LEN);
    thresh    = (32'(i_fifo_cnt) >= blen_calc);
    frame_sum = 32'(frame_cnt_q) + 32'(blen_q);
    frame_base = P_BASE_ADDR + (buf_sel_q ? P_FRAME_OFFSET : 27'h0);
    in_burst  = (state_q == S_BURST);
    wr_en     = in_burst & i_response & i_app_wdf_rdy &
                (dat_cnt_q < blen_q);
    cmd_valid = in_burst & i_response & (cmd_cnt_q < dat_cnt_q);
    cmd_acc   = cmd_valid & i_app_rdy;
  end

  // Next-state, counters and address update.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    blen_d       = blen_q;
    cmd_cnt_d    = cmd_cnt_q;
    dat_cnt_d    = dat_cnt_q;
    req_addr_d   = req_addr_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_frame_start) begin
          frame_cnt_d = '0;
          req_addr_d  = frame_base;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (thresh) begin
          blen_d  = BW'(blen_calc);
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (i_response) begin
          cmd_cnt_d = '0;
          dat_cnt_d = '0;
          state_d   = S_BURST;
        end
      end
      S_BURST: begin
        if (wr_en) begin
          dat_cnt_d = dat_cnt_q + BW'(1);
        end
        if (cmd_acc) begin
          cmd_cnt_d  = cmd_cnt_q + BW'(1);
          req_addr_d = req_addr_q + 27'(P_ADDR_STEP);
        end
        if ((cmd_cnt_q == blen_q) && (dat_cnt_q == blen_q)) begin
          state_d = S_END;
        end
      end
      S_END: begin
        frame_cnt_d = FW'(frame_sum);
        if (frame_sum == 32'(P_FRAME_WORDS)) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    request_d = (state_d == S_REQ) | (state_d == S_BURST);
    if (!i_system_init) begin
      state_d      = S_IDLE;
      frame_cnt_d  = '0;
      blen_d       = '0;
      cmd_cnt_d    = '0;
      dat_cnt_d    = '0;
      req_addr_d   = P_BASE_ADDR;
      request_d    = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge i_ddr3_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      frame_cnt_q  <= '0;
      blen_q       <= '0;
      cmd_cnt_q    <= '0;
      dat_cnt_q    <= '0;
      req_addr_q   <= P_BASE_ADDR;
      request_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      blen_q       <= blen_d;
      cmd_cnt_q    <= cmd_cnt_d;
      dat_cnt_q    <= dat_cnt_d;
      req_addr_q   <= req_addr_d;
      request_q    <= request_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_fifo_rd    = wr_en;
  assign o_wr_en      = wr_en;
  assign o_wr_data    = i_fifo_data;
  assign o_cmd_valid  = cmd_valid;
  assign o_req_addr   = req_addr_q;
  assign o_request    = request_q;
  assign o_rdwr_cmd   = 3'b000;
  assign o_bust_end   = (state_q == S_END);
  assign o_frame_done = frame_done_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_frmbuf_wr_req.sv
// Bench for frmbuf_wr_req: directed phases with randomized handshakes,
// checked against a frame/burst level model of addresses and FIFO order.
module tb_frmbuf_wr_req;

  localparam int BL   = 4;
  localparam int FW   = 10;
  localparam int STEP = 8;
  localparam int BASE = 32'h100;
  localparam int OFFS = 32'h1000;

  logic         clk = 1'b0;
  logic         i_rst_n = 1'b1;
  logic         i_system_init = 1'b0;
  logic         i_frame_start = 1'b0;
  logic [9:0]   i_fifo_cnt = '0;
  logic [255:0] i_fifo_data = '0;
  logic         o_fifo_rd;
  logic         o_request;
  logic         i_response = 1'b0;
  logic         o_bust_end;
  logic [26:0]  o_req_addr;
  logic         o_cmd_valid;
  logic [2:0]   o_rdwr_cmd;
  logic         o_wr_en;
  logic [255:0] o_wr_data;
  logic         i_app_rdy = 1'b0;
  logic         i_app_wdf_rdy = 1'b0;
  logic         o_frame_done;
  logic         o_busy;
`ifdef FRMBUF_WR_PINGPONG_EN
  logic         o_buf_sel;
`endif

  frmbuf_wr_req #(
    .P_BURST_LEN   (BL),
    .P_FRAME_WORDS (FW),
    .P_BASE_ADDR   (27'h100),
    .P_ADDR_STEP   (STEP),
    .P_FRAME_OFFSET(27'h1000)
  ) dut (
    .i_ddr3_clk   (clk),
    .i_rst_n      (i_rst_n),
    .i_system_init(i_system_init),
    .i_frame_start(i_frame_start),
    .i_fifo_cnt   (i_fifo_cnt),
    .i_fifo_data  (i_fifo_data),
    .o_fifo_rd    (o_fifo_rd),
    .o_request    (o_request),
    .i_response   (i_response),
    .o_bust_end   (o_bust_end),
    .o_req_addr   (o_req_addr),
    .o_cmd_valid  (o_cmd_valid),
    .o_rdwr_cmd   (o_rdwr_cmd),
    .o_wr_en      (o_wr_en),
    .o_wr_data    (o_wr_data),
    .i_app_rdy    (i_app_rdy),
    .i_app_wdf_rdy(i_app_wdf_rdy),
    .o_frame_done (o_frame_done),
`ifdef FRMBUF_WR_PINGPONG_EN
    .o_buf_sel    (o_buf_sel),
`endif
    .o_busy       (o_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [255:0] mem [128];
  int  pop_idx = 0;
  int  app_mode = 0;
  int  wdf_mode = 0;
  bit  resp_rand = 0;
  bit  tog = 0;
  bit  last_req = 0;
  bit  stall_prev = 0;
  logic [26:0] prev_addr = '0;
  bit  exp_sel = 0;
  int  exp_base = BASE;
  int  words_frame = 0;
  int  cmds_frame = 0;
  int  words_burst = 0;
  int  cmds_burst = 0;
  int  bursts = 0;
  int  frames = 0;

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic pick(input int mode);
    case (mode)
      0: return 1'b1;
      1: return tog;
      2: return 1'($urandom_range(1));
      default: return 1'b0;
    endcase
  endfunction

  task automatic monitor();
    int exp_len;
    if (o_cmd_valid) begin
      chk("cmd_gate", i_response, 1'b1);
      chk("cmd_after_data", cmds_burst < words_burst, 1'b1);
      if (stall_prev) chk("addr_stable", o_req_addr, prev_addr);
      if (i_app_rdy) begin
        chk("cmd_addr", o_req_addr, exp_base + STEP * cmds_frame);
        cmds_frame++;
        cmds_burst++;
      end
    end
    stall_prev = o_cmd_valid && !i_app_rdy;
    prev_addr = o_req_addr;
    if (o_wr_en) begin
      chk("wr_gate", i_response && i_app_wdf_rdy, 1'b1);
      chk("fifo_rd", o_fifo_rd, 1'b1);
      chk("wr_data", o_wr_data, mem[pop_idx % 128]);
      pop_idx++;
      words_burst++;
      words_frame++;
    end
    if (o_bust_end) begin
      exp_len = imin(BL, FW - (words_frame - words_burst));
      chk("burst_words", words_burst, exp_len);
      chk("burst_cmds", cmds_burst, exp_len);
      bursts++;
      words_burst = 0;
      cmds_burst = 0;
    end
    if (o_frame_done) begin
      chk("frame_words", words_frame, FW);
      chk("frame_cmds", cmds_frame, FW);
      chk("frame_bursts", bursts, 3);
      frames++;
`ifdef FRMBUF_WR_PINGPONG_EN
      exp_sel = !exp_sel;
      chk("buf_sel_toggle", o_buf_sel, exp_sel);
`endif
    end
  endtask

  task automatic tick();
    tog = !tog;
    i_response = last_req && (resp_rand ? ($urandom_range(3) != 0) : 1'b1);
    i_app_rdy = pick(app_mode);
    i_app_wdf_rdy = pick(wdf_mode);
    i_fifo_data = mem[pop_idx % 128];
    #1;
    monitor();
    last_req = o_request;
    @(negedge clk);
  endtask

  task automatic start_frame();
    words_frame = 0;
    cmds_frame = 0;
    words_burst = 0;
    cmds_burst = 0;
    bursts = 0;
    stall_prev = 0;
    exp_base = BASE + (exp_sel ? OFFS : 0);
    i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    int f0 = frames;
    while (frames == f0 && n < 300) begin
      tick();
      n++;
    end
    chk(tag, frames != f0, 1'b1);
    chk("idle_after_frame", o_busy, 1'b0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 128; i++) begin
      mem[i] = {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    end
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_request", o_request, 1'b0);
    chk("rst_addr", o_req_addr, BASE);
    chk("rst_wr_en", o_wr_en, 1'b0);
    chk("rst_cmd_valid", o_cmd_valid, 1'b0);
    chk("rst_bust_end", o_bust_end, 1'b0);
    chk("rst_frame_done", o_frame_done, 1'b0);
    chk("rst_rdwr", o_rdwr_cmd, 3'b000);
`ifdef FRMBUF_WR_PINGPONG_EN
    chk("rst_buf_sel", o_buf_sel, 1'b0);
`endif
    @(negedge clk);
    i_rst_n = 1'b1;
    i_system_init = 1'b1;
    i_fifo_cnt = 10'd16;
    tick();

    // Full-rate frame.
    start_frame();
    wait_done("t2_frame_timeout");

    // Command-ready toggling each cycle.
    app_mode = 1;
    start_frame();
    wait_done("t3_frame_timeout");

    // Fully random handshakes, two frames.
    app_mode = 2;
    wdf_mode = 2;
    resp_rand = 1;
    for (int f = 0; f < 2; f++) begin
      start_frame();
      wait_done("rand_frame_timeout");
    end
    app_mode = 0;
    wdf_mode = 0;
    resp_rand = 0;

    // FIFO threshold, including short final burst.
    i_fifo_cnt = 10'd3;
    start_frame();
    repeat (5) begin
      tick();
      chk("no_req_below_thresh", o_request, 1'b0);
    end
    i_fifo_cnt = 10'd4;
    tick();
    chk("req_after_thresh", o_request, 1'b1);
    n = 0;
    while (frames == 0 + frames && n < 300 && !o_frame_done) begin
      if (bursts >= 2) i_fifo_cnt = 10'd2;
      tick();
      n++;
      if (bursts == 3) break;
    end
    chk("t4_short_burst_done", bursts, 3);
    tick();
    tick();
    chk("t4_idle", o_busy, 1'b0);
    i_fifo_cnt = 10'd16;

    // Calibration loss mid-burst.
    start_frame();
    n = 0;
    while (words_burst < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("abort_reached", words_burst, 2);
    app_mode = 3;
    wdf_mode = 3;
    i_system_init = 1'b0;
    tick();
    chk("abort_busy", o_busy, 1'b0);
    chk("abort_request", o_request, 1'b0);
    chk("abort_bust_end", o_bust_end, 1'b0);
    chk("abort_addr", o_req_addr, BASE);
    tick();
    chk("abort_bust_end2", o_bust_end, 1'b0);
    i_system_init = 1'b1;
    app_mode = 0;
    wdf_mode = 0;
    tick();
    start_frame();
    wait_done("t5_restart_timeout");

    // Asynchronous reset mid-burst.
    start_frame();
    n = 0;
    while (words_frame < 1 && n < 50) begin
      tick();
      n++;
    end
    #3 i_rst_n = 1'b0;
    #1;
    chk("arst_busy", o_busy, 1'b0);
    chk("arst_request", o_request, 1'b0);
    chk("arst_wr_en", o_wr_en, 1'b0);
    chk("arst_fifo_rd", o_fifo_rd, 1'b0);
    chk("arst_cmd_valid", o_cmd_valid, 1'b0);
    chk("arst_bust_end", o_bust_end, 1'b0);
    chk("arst_addr", o_req_addr, BASE);
    exp_sel = 0;
    last_req = 0;
`ifdef FRMBUF_WR_PINGPONG_EN
    chk("arst_buf_sel", o_buf_sel, 1'b0);
`endif
    @(negedge clk);
    i_rst_n = 1'b1;
    tick();

    // Two back-to-back frames after reset (buffer alternation when enabled).
    for (int f = 0; f < 2; f++) begin
      start_frame();
      wait_done("t6_frame_timeout");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
